// File: rtl/arm_fetch.sv
// Fetch stage: word-aligned imem reads into an in-order {pc, word} queue that feeds decode over valid/ready.
// Zero-wait memory shows the first inst two cycles after its request; a redirect flushes the queue and drops in-flight words.
module arm_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc_q, rsp_pc_q, redir_pc;
  logic [31:0]   pc_q   [DEPTH];
  logic [31:0]   word_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q, count_d, out_q, out_d, drop_q, drop_d;
  logic [CW:0]   credit;
  logic          req_fire, rsp_take, push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Every accepted request owns a queue slot until its word is popped or dropped,
  // so a push can never land on a full queue.
  assign credit         = {1'b0, out_q} + {1'b0, count_q};
  assign imem_req_valid = reset_n && !redirect_valid && (credit < DEPTH_W);
  assign imem_addr      = fetch_pc_q;
  assign inst_valid     = reset_n && !redirect_valid && (count_q != '0);
  assign inst           = word_q[rd_ptr_q];
  assign inst_pc        = pc_q[rd_ptr_q];
  assign redir_pc       = redirect_pc & 32'hFFFF_FFFC;

  always_comb begin
    rsp_take = imem_rsp_valid && (out_q != '0);
    req_fire = imem_req_valid && imem_req_ready;
    pop      = inst_valid && inst_ready;
    push     = rsp_take && (drop_q == '0) && !redirect_valid;

    out_d = out_q;
    if (req_fire && !rsp_take)      out_d = out_q + CW'(1);
    else if (rsp_take && !req_fire) out_d = out_q - CW'(1);

    // On redirect every request still in flight after this cycle becomes stale.
    drop_d = drop_q;
    if (redirect_valid)                      drop_d = out_d;
    else if (rsp_take && (drop_q != '0))     drop_d = drop_q - CW'(1);

    count_d = count_q;
    if (redirect_valid)     count_d = '0;
    else if (push && !pop)  count_d = count_q + CW'(1);
    else if (pop && !push)  count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      out_q      <= '0;
      drop_q     <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_q[i]   <= '0;
        word_q[i] <= '0;
      end
    end else begin
      out_q   <= out_d;
      drop_q  <= drop_d;
      count_q <= count_d;
      if (redirect_valid) begin
        fetch_pc_q <= redir_pc;
        rsp_pc_q   <= redir_pc;
        rd_ptr_q   <= '0;
        wr_ptr_q   <= '0;
      end else begin
        if (req_fire) fetch_pc_q <= fetch_pc_q + 32'd4;
        if (push) begin
          pc_q[wr_ptr_q]   <= rsp_pc_q;
          word_q[wr_ptr_q] <= imem_rsp_data;
          wr_ptr_q         <= ptr_inc(wr_ptr_q);
          rsp_pc_q         <= rsp_pc_q + 32'd4;
        end
        if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
    end
  end

endmodule

// File: tb/tb_arm_fetch.sv
// Bench for arm_fetch: in-order latency memory model plus a queue-level reference of the fetch stage.
module tb_arm_fetch;

  localparam logic [31:0] RPC   = 32'hFFFF_FFF8;
  localparam int          DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset_n, imem_req_ready, imem_rsp_valid, inst_ready, redirect_valid;
  logic [31:0] imem_rsp_data, redirect_pc;
  logic        imem_req_valid, inst_valid;
  logic [31:0] imem_addr, inst, inst_pc;

  always #5 clk = ~clk;

  arm_fetch #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  typedef struct { logic [31:0] pc; logic [31:0] w; } ent_t;

  int checks = 0, failures = 0, cyc = 0;
  // reference state
  logic [31:0] m_fpc, m_rpc;
  ent_t        m_q[$];
  int          m_out, m_drop;
  bit          m_pushed;
  // memory and stimulus knobs
  int          mem_due[$];
  logic [31:0] mem_addr[$];
  int          lat_min = 1, lat_max = 1, p_rdy = 100, p_ird = 100, p_red = 0;
  bit          hold_rst = 1'b1, stray = 1'b0, hit;
  logic [31:0] got_pc[$], got_inst[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  task automatic m_reset();
    m_fpc = RPC; m_rpc = RPC; m_q.delete(); m_out = 0; m_drop = 0; m_pushed = 0;
  endtask

  task automatic cyc_begin();
    @(posedge clk); #1;
    cyc++;
    reset_n        = !hold_rst;
    imem_req_ready = ($urandom_range(99) < p_rdy);
    inst_ready     = ($urandom_range(99) < p_ird);
    redirect_valid = ($urandom_range(99) < p_red);
    redirect_pc    = $urandom;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (mem_due.size() != 0 && mem_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_addr[0] ^ 32'hA5A5_0000;
      void'(mem_due.pop_front());
      void'(mem_addr.pop_front());
    end
    if (stray) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
      stray = 1'b0;
    end
  endtask

  task automatic cyc_end();
    bit          e_req, e_iv, take, fire, pop;
    logic [31:0] e_inst, e_pc;
    int          due;
    @(negedge clk);
    e_req  = reset_n && !redirect_valid && (m_out + m_q.size() < DEPTH);
    e_iv   = reset_n && !redirect_valid && (m_q.size() != 0);
    e_inst = (m_q.size() != 0) ? m_q[0].w  : 32'd0;
    e_pc   = (m_q.size() != 0) ? m_q[0].pc : 32'd0;
    check("imem_req_valid", {31'd0, imem_req_valid}, {31'd0, e_req});
    check("imem_addr", imem_addr, m_fpc);
    check("inst_valid", {31'd0, inst_valid}, {31'd0, e_iv});
    if (e_iv || !m_pushed) begin
      check("inst", inst, e_inst);
      check("inst_pc", inst_pc, e_pc);
    end
    if (inst_valid && inst_ready) begin
      got_pc.push_back(inst_pc);
      got_inst.push_back(inst);
    end
    if (!reset_n) begin
      m_reset();
      mem_due.delete();
      mem_addr.delete();
    end else begin
      take = imem_rsp_valid && (m_out != 0);
      fire = e_req && imem_req_ready;
      pop  = e_iv && inst_ready;
      if (fire) begin
        due = cyc + $urandom_range(lat_max, lat_min);
        if (mem_due.size() != 0 && due <= mem_due[$]) due = mem_due[$] + 1;
        mem_due.push_back(due);
        mem_addr.push_back(m_fpc);
      end
      m_out = m_out + int'(fire) - int'(take);
      if (redirect_valid) begin
        m_drop = m_out;
        m_fpc  = redirect_pc & 32'hFFFF_FFFC;
        m_rpc  = m_fpc;
        m_q.delete();
      end else begin
        if (pop) void'(m_q.pop_front());
        if (take) begin
          if (m_drop > 0) m_drop--;
          else begin
            m_q.push_back('{pc: m_rpc, w: imem_rsp_data});
            m_rpc    = m_rpc + 32'd4;
            m_pushed = 1'b1;
          end
        end
        if (fire) m_fpc = m_fpc + 32'd4;
      end
    end
  endtask

  task automatic tick();
    cyc_begin();
    cyc_end();
  endtask

  task automatic wait_pop(input string name);
    int n = 0;
    while (got_pc.size() == 0 && n < 20) begin tick(); n++; end
    check(name, {31'd0, got_pc.size() != 0}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    m_reset();
    repeat (3) tick();
    check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_addr", imem_addr, 32'hFFFF_FFF8);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);

    // zero-wait memory from reset; pc wraps past 0xFFFF_FFFC
    hold_rst = 1'b0;
    got_pc.delete(); got_inst.delete();
    repeat (3) tick();
    check("first_valid_c2", {31'd0, inst_valid}, 32'd1);
    check("first_pc_c2", inst_pc, 32'hFFFF_FFF8);
    repeat (10) tick();
    check("wrap_count", {31'd0, got_pc.size() >= 3}, 32'd1);
    if (got_pc.size() >= 3) begin
      check("wrap_pc0", got_pc[0], 32'hFFFF_FFF8);
      check("wrap_pc1", got_pc[1], 32'hFFFF_FFFC);
      check("wrap_pc2", got_pc[2], 32'h0000_0000);
      check("wrap_inst2", got_inst[2], 32'hA5A5_0000);
    end

    // decode stall: buffer fills and requests stop
    p_ird = 0;
    repeat (10) tick();
    check("stall_req_off", {31'd0, imem_req_valid}, 32'd0);
    check("stall_valid", {31'd0, inst_valid}, 32'd1);
    p_ird = 100;
    got_pc.delete(); got_inst.delete();
    repeat (12) tick();
    for (int i = 1; i < got_pc.size(); i++)
      check("stall_order", got_pc[i], got_pc[i-1] + 32'd4);

    // redirect with two requests in flight on a 3-cycle memory
    hold_rst = 1'b1; repeat (2) tick();
    hold_rst = 1'b0; lat_min = 3; lat_max = 3;
    hit = 1'b0;
    for (int i = 0; i < 12 && !hit; i++) begin
      cyc_begin();
      if (m_out == 2 && !imem_rsp_valid) begin
        redirect_valid = 1'b1; redirect_pc = 32'h0000_1002; hit = 1'b1;
      end
      cyc_end();
    end
    check("redir_hit", {31'd0, hit}, 32'd1);
    got_pc.delete(); got_inst.delete();
    tick();
    check("redir_addr", imem_addr, 32'h0000_1000);
    wait_pop("redir_pop_timeout");
    if (got_pc.size() != 0) begin
      check("redir_pc", got_pc[0], 32'h0000_1000);
      check("redir_inst", got_inst[0], 32'hA5A5_1000);
    end

    // redirect colliding with a response and a would-be pop
    lat_min = 1; lat_max = 1;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      cyc_begin();
      if (imem_rsp_valid && m_out != 0 && m_q.size() != 0 && inst_ready) begin
        redirect_valid = 1'b1; redirect_pc = 32'h0000_2003; hit = 1'b1;
      end
      cyc_end();
    end
    check("coll_hit", {31'd0, hit}, 32'd1);
    check("coll_valid_low", {31'd0, inst_valid}, 32'd0);
    got_pc.delete(); got_inst.delete();
    wait_pop("coll_pop_timeout");
    if (got_pc.size() != 0) check("coll_pc", got_pc[0], 32'h0000_2000);

    // randomized traffic
    p_rdy = 70; p_ird = 60; p_red = 4; lat_min = 1; lat_max = 4;
    repeat (3000) tick();

    // reset mid-stream with responses pending, then a stray response
    p_red = 0; p_ird = 50; lat_min = 2; lat_max = 2;
    for (int i = 0; i < 20 && mem_due.size() == 0; i++) tick();
    check("mid_pending", {31'd0, mem_due.size() != 0}, 32'd1);
    hold_rst = 1'b1; tick(); tick();
    check("mid_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("mid_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("mid_addr", imem_addr, 32'hFFFF_FFF8);
    check("mid_inst", inst, 32'd0);
    check("mid_inst_pc", inst_pc, 32'd0);
    hold_rst = 1'b0; stray = 1'b1; p_ird = 100; p_rdy = 100;
    got_pc.delete(); got_inst.delete();
    tick();
    wait_pop("mid_pop_timeout");
    if (got_pc.size() != 0) begin
      check("mid_restart_pc", got_pc[0], 32'hFFFF_FFF8);
      check("mid_restart_inst", got_inst[0], 32'h5A5A_FFF8);
    end
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
